alu_mdu: RTL and testbench

Parametrised successor to the pipeline's combinational ALU: a registered ALU plus an iterative multiply/divide unit with HI/LO registers, behind a valid/ready handshake. It sits in the EX stage. Single-cycle ALU ops return one cycle after acceptance. MULT/MULTU/DIV/DIVU stall the stage through `in_ready` until the iterative result is ready.

---
 rtl/alu_mdu.sv | 262 ++++++++++++++++++++++++++
 tb/tb_alu_mdu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: registered ALU plus an iterative multiply/divide unit with HI/LO
// registers. Single-cycle ops return one cycle after acceptance. MULT/DIV
// run a magnitude engine with one bit per cycle, then correct the sign in FIX.
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_ONE = 1;
    localparam logic [SHW-1:0] SH_ONE  = 1;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd;
    logic [WIDTH-1:0]     r_a;
    logic                 r_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_zero;
    logic                 r_carry;
    logic                 r_neg;
    logic                 r_ovf;

    // Handshake and op decode
    logic w_in_ready, w_accept, w_muldiv, w_is_mul, w_is_div, w_sa, w_sb;
    logic [WIDTH-1:0] w_ma, w_mb;

    assign w_in_ready = rst_n && (r_state == S_IDLE || (r_state == S_DONE && out_ready));
    assign w_accept   = in_valid && w_in_ready && !flush;
    assign w_muldiv   = (op[4:2] == 3'b100);
    assign w_is_mul   = w_muldiv && !op[1];
    assign w_is_div   = w_muldiv && op[1];
    // op[0]==0 selects the signed variant (MULT/DIV)
    assign w_sa       = !op[0] && a[WIDTH-1];
    assign w_sb       = !op[0] && b[WIDTH-1];
    assign w_ma       = w_sa ? -a : a;
    assign w_mb       = w_sb ? -b : b;

    // Single-cycle datapath terms
    logic [SHW-1:0]   w_sh, w_rbit, w_lbit;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff, w_sra, w_srl, w_sll;
    logic             w_lt_s, w_lt_u, w_rc, w_lc;

    assign w_sh   = a[SHW-1:0];
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = a - b;
    assign w_lt_s = $signed(a) < $signed(b);
    assign w_lt_u = a < b;
    assign w_sra  = $unsigned($signed(b) >>> w_sh);
    assign w_srl  = b >> w_sh;
    assign w_sll  = b << w_sh;
    assign w_rbit = w_sh - SH_ONE;
    assign w_lbit = SHW'(WIDTH - int'(w_sh));
    assign w_rc   = (w_sh != '0) && b[w_rbit];
    assign w_lc   = (w_sh != '0) && b[w_lbit];

    logic [WIDTH-1:0] w_res;
    logic w_c, w_v, w_z, w_n, w_slt, w_rsv;

    // Single-cycle result and flag selection
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_slt = 1'b0;
        w_rsv = 1'b0;
        if (!op[4]) begin
            case (op[3:0])
                4'b0000, 4'b0010: begin
                    w_res = w_sum[WIDTH-1:0];
                    w_c   = w_sum[WIDTH];
                    w_v   = op[1] && (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
                end
                4'b0001, 4'b0011: begin
                    w_res = w_diff;
                    w_c   = w_lt_u;
                    w_v   = op[1] && (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
                end
                4'b0100: w_res = a & b;
                4'b0101: w_res = a | b;
                4'b0110: w_res = a ^ b;
                4'b0111: w_res = ~(a | b);
                4'b1000, 4'b1001: w_res = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
                4'b1011: begin
                    w_res = {{(WIDTH-1){1'b0}}, w_lt_s};
                    w_slt = 1'b1;
                end
                4'b1010: begin
                    w_res = {{(WIDTH-1){1'b0}}, w_lt_u};
                    w_c   = w_lt_u;
                    w_slt = 1'b1;
                end
                4'b1100: begin
                    w_res = w_sra;
                    w_c   = w_rc;
                end
                4'b1101: begin
                    w_res = w_srl;
                    w_c   = w_rc;
                end
                default: begin
                    w_res = w_sll;
                    w_c   = w_lc;
                end
            endcase
        end else begin
            case (op[3:0])
                4'b0100:          w_res = r_hi;
                4'b0101:          w_res = r_lo;
                4'b0110, 4'b0111: w_res = a;
                default:          w_rsv = op[3];
            endcase
        end
        w_z = w_slt ? (a == b) : ((w_res == '0) && !w_rsv);
        w_n = (op == 5'b01011) ? w_res[0] : w_res[WIDTH-1];
    end

    // Iteration step: shift-add multiply and restoring divide
    logic [WIDTH:0]       w_madd, w_rsh, w_dsub;
    logic [2*WIDTH-1:0]   w_mnext, w_dnext;
    logic                 w_ge;

    assign w_madd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    assign w_mnext = r_acc[0] ? {w_madd, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};
    assign w_rsh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_dsub  = w_rsh - {1'b0, r_opnd};
    assign w_ge    = w_rsh >= {1'b0, r_opnd};
    assign w_dnext = w_ge ? {w_dsub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                          : {w_rsh[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b0};

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

    // Sign correction of the magnitude result; divide by zero bypasses it
    always_comb begin
        w_prod   = r_neg_q ? -r_acc : r_acc;
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_div) begin
            if (r_opnd == '0) begin
                w_fix_lo = '1;
                w_fix_hi = r_a;
            end else begin
                w_fix_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                w_fix_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            end
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept)
                    w_next = w_is_mul ? S_MUL : (w_is_div ? S_DIV : S_DONE);
                else if (r_state == S_DONE && out_ready)
                    w_next = S_IDLE;
            end
            S_MUL, S_DIV: if (r_cnt == CNT_ONE) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Engine operands and accumulator, loaded on MULT/DIV acceptance
    always_ff @(posedge clk) begin
        if (w_accept && w_muldiv) begin
            r_div   <= w_is_div;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_a     <= a;
            r_opnd  <= w_is_mul ? w_ma : w_mb;
            r_acc   <= {{WIDTH{1'b0}}, (w_is_mul ? w_mb : w_ma)};
        end else if (r_state == S_MUL) begin
            r_acc <= w_mnext;
        end else if (r_state == S_DIV) begin
            r_acc <= w_dnext;
        end
    end

    // Counter, result/flags and HI/LO architectural state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            if (w_muldiv) begin
                r_cnt <= CW'(WIDTH);
            end else begin
                r_result <= w_res;
                r_zero   <= w_z;
                r_carry  <= w_c;
                r_neg    <= w_n;
                r_ovf    <= w_v;
                if (op == 5'b10110) r_hi <= a;
                if (op == 5'b10111) r_lo <= a;
            end
        end else if (r_state == S_MUL || r_state == S_DIV) begin
            r_cnt <= r_cnt - CNT_ONE;
        end else if (r_state == S_FIX) begin
            // completes even when flushed in this cycle
            r_hi     <= w_fix_hi;
            r_lo     <= w_fix_lo;
            r_result <= w_fix_lo;
            r_zero   <= (w_fix_lo == '0);
            r_carry  <= 1'b0;
            r_neg    <= w_fix_lo[WIDTH-1];
            r_ovf    <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign negative  = r_neg;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu at WIDTH=32: ALU vector table, MDU sequences,
// backpressure, flush and reset corner cases.
module tb_alu_mdu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]   op;
    logic [W-1:0] a, b, result, hi, lo;
    logic         zero, carry, negative, overflow;

    int n_vec  = 0;
    int n_miss = 0;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .hi(hi), .lo(lo), .zero(zero), .carry(carry),
        .negative(negative), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  zcnv;
    } vec_t;

    vec_t vt[23];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Accept a MULT/DIV, hold out_ready low and check the busy window and results.
    task automatic run_md(input string nm, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        logic bad;
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        bad = 1'b0;
        for (int k = 1; k <= W + 1; k++) begin
            if (in_ready || out_valid) bad = 1'b1;
            step();
        end
        check({nm, "_busy"}, {63'd0, bad}, 64'd0);
        check({nm, "_done"}, {62'd0, out_valid, in_ready}, 64'd2);
        check({nm, "_hilo"}, {hi, lo}, {eh, el});
        check({nm, "_res"}, {32'd0, result}, {32'd0, el});
        out_ready = 1'b1;
        step();
    endtask

    task automatic single(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic bad;
        vt[0]  = '{5'b00010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011};
        vt[1]  = '{5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100};
        vt[2]  = '{5'b00011, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001};
        vt[3]  = '{5'b00001, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 4'b0110};
        vt[4]  = '{5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010};
        vt[5]  = '{5'b00101, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000};
        vt[6]  = '{5'b00110, 32'hAAAA5555, 32'hAAAA5555, 32'h00000000, 4'b1000};
        vt[7]  = '{5'b00111, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0010};
        vt[8]  = '{5'b01000, 32'h00000000, 32'h12345678, 32'h56780000, 4'b0000};
        vt[9]  = '{5'b01001, 32'h00000000, 32'h0000FFFF, 32'hFFFF0000, 4'b0010};
        vt[10] = '{5'b01011, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0010};
        vt[11] = '{5'b01011, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1000};
        vt[12] = '{5'b01010, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 4'b0100};
        vt[13] = '{5'b01100, 32'h00000004, 32'h80000000, 32'hF8000000, 4'b0010};
        vt[14] = '{5'b01100, 32'h00000024, 32'h0000000F, 32'h00000000, 4'b1100};
        vt[15] = '{5'b01101, 32'h00000001, 32'h80000001, 32'h40000000, 4'b0100};
        vt[16] = '{5'b01110, 32'h00000021, 32'h80000001, 32'h00000002, 4'b0100};
        vt[17] = '{5'b01111, 32'h00000000, 32'h12345678, 32'h12345678, 4'b0000};
        vt[18] = '{5'b11000, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0000};
        vt[19] = '{5'b10110, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 4'b0010};
        vt[20] = '{5'b10100, 32'h00000000, 32'h00000000, 32'hDEADBEEF, 4'b0010};
        vt[21] = '{5'b10111, 32'h00000000, 32'h00000000, 32'h00000000, 4'b1000};
        vt[22] = '{5'b10101, 32'h00000000, 32'h00000000, 32'h00000000, 4'b1000};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;
        step(); step();
        check("reset_state", {in_ready, out_valid, result, zero, carry, negative, overflow}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        step();
        check("idle_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 23; i++) begin
            in_valid = 1'b1; op = vt[i].op; a = vt[i].a; b = vt[i].b;
            step();
            check($sformatf("vec%0d", i), {27'd0, out_valid, result, zero, carry, negative, overflow},
                  {27'd0, 1'b1, vt[i].res, vt[i].zcnv});
        end
        in_valid = 1'b0;
        step();
        check("drain_idle", {63'd0, out_valid}, 64'd0);
        check("mt_hilo", {hi, lo}, {32'hDEADBEEF, 32'h0});

        run_md("mult_neg", 5'b10000, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        single(5'b10100, 0, 0);
        check("mfhi_after_mult", {32'd0, result}, {32'd0, 32'hFFFFFFFF});
        step();
        run_md("multu_max", 5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_md("div_neg", 5'b10010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu_zero", 5'b10011, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF);
        run_md("div_min", 5'b10010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run_md("div_negzero", 5'b10010, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_md("divu_100_7", 5'b10011, 32'd100, 32'd7, 32'd2, 32'd14);
        run_md("div_7_m2", 5'b10010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);

        // Backpressure: result held, next op accepted on release
        in_valid = 1'b1; op = 5'b00000; a = 32'd1; b = 32'd2; out_ready = 1'b0;
        step();
        op = 5'b00010; a = 32'd5; b = 32'd6;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!out_valid || in_ready || result !== 32'd3 ||
                {zero, carry, negative, overflow} !== 4'b0000) bad = 1'b1;
            step();
        end
        check("bp_hold", {63'd0, bad}, 64'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        step();
        check("bp_next", {27'd0, out_valid, result, zero, carry, negative, overflow},
              {27'd0, 1'b1, 32'd11, 4'b0000});
        in_valid = 1'b0;
        step();

        // Flush at cycle 10 of a DIVU
        single(5'b10110, 32'h11111111, 0);
        single(5'b10111, 32'h22222222, 0);
        step();
        single(5'b10011, 32'd100, 32'd7);
        for (int k = 1; k < 10; k++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_idle", {62'd0, out_valid, in_ready}, 64'd1);
        bad = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            if (out_valid) bad = 1'b1;
            step();
        end
        check("flush_no_valid", {63'd0, bad}, 64'd0);
        check("flush_hilo", {hi, lo}, {32'h11111111, 32'h22222222});

        // No acceptance on a flush edge
        flush = 1'b1; in_valid = 1'b1; op = 5'b10110; a = 32'h33333333;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_blocks_accept", {31'd0, out_valid, hi}, {31'd0, 1'b0, 32'h11111111});

        // Flush during FIX still writes HI/LO
        single(5'b10000, 32'd3, 32'd4);
        for (int k = 0; k < W; k++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_fix", {31'd0, out_valid, hi, lo}, {31'd0, 1'b0, 32'd0, 32'd12});

        // Reset mid-MULT
        single(5'b00000, 32'd1, 32'd2);
        step();
        single(5'b10000, 32'd7, 32'd9);
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        step();
        check("rst_mid_mult", {in_ready, out_valid, result, zero, carry, negative, overflow}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;
        step();
        check("rst_recover", {62'd0, out_valid, in_ready}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
